// File: rtl/mac_accum.sv
// Pipelined fixed-point multiply-accumulate: registered product, then saturating
// accumulation over LEN-term windows with one result pulse per window.
module mac_accum #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 24,
  parameter int LEN    = 9,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] pixel,
  input  logic [DATA_W-1:0] weight,
  output logic [DATA_W-1:0] result,
  output logic              out_valid,
  output logic              sat,
  output logic              busy
);

  localparam int PW    = 2 * DATA_W;
  localparam int EW    = ((PW > ACC_W) ? PW : ACC_W) + 2;
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  localparam logic signed [EW-1:0] ACC_MAX = (SIGNED != 0) ?
    (EW'(1) <<< (ACC_W - 1)) - EW'(1) : (EW'(1) <<< ACC_W) - EW'(1);
  localparam logic signed [EW-1:0] ACC_MIN = (SIGNED != 0) ?
    -(EW'(1) <<< (ACC_W - 1)) : EW'(0);
  localparam logic signed [EW-1:0] RES_MAX = (SIGNED != 0) ?
    (EW'(1) <<< (DATA_W - 1)) - EW'(1) : (EW'(1) <<< DATA_W) - EW'(1);
  localparam logic signed [EW-1:0] RES_MIN = (SIGNED != 0) ?
    -(EW'(1) <<< (DATA_W - 1)) : EW'(0);

  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    product;
  logic             p_valid;
  logic             p_first;
  logic             p_last;
  logic [ACC_W-1:0] acc;
  logic             wflag;

  logic [PW-1:0] pixel_x, weight_x, prod_c;

  // Operands are widened to the full product width first, so one unsigned
  // multiply gives the correct low PW bits for both signed and unsigned modes.
  always_comb begin
    pixel_x  = {{DATA_W{(SIGNED != 0) & pixel[DATA_W-1]}}, pixel};
    weight_x = {{DATA_W{(SIGNED != 0) & weight[DATA_W-1]}}, weight};
    prod_c   = pixel_x * weight_x;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      product <= '0;
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      p_valid <= 1'b0;
    end else begin
      p_valid <= in_valid;
      if (in_valid) begin
        product <= prod_c;
        p_first <= (cnt == '0);
        p_last  <= (cnt == LAST);
        cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  logic signed [EW-1:0] prod_e, term_raw, term_s, acc_e, sum, acc_sat, res_sat;
  logic                 term_clip, acc_clip, res_clip, flag_next;
  logic [ACC_W-1:0]     acc_next;

  // All clamping happens in a signed domain two bits wider than any operand,
  // so intermediate sums can never wrap before being compared.
  always_comb begin
    prod_e   = {{(EW-PW){(SIGNED != 0) & product[PW-1]}}, product};
    term_raw = prod_e >>> FRAC_W;
    term_s   = term_raw;
    term_clip = 1'b0;
    if (term_raw > ACC_MAX) begin
      term_s    = ACC_MAX;
      term_clip = 1'b1;
    end else if (term_raw < ACC_MIN) begin
      term_s    = ACC_MIN;
      term_clip = 1'b1;
    end

    acc_e = {{(EW-ACC_W){(SIGNED != 0) & acc[ACC_W-1]}}, acc};
    sum   = p_first ? term_s : acc_e + term_s;
    acc_sat  = sum;
    acc_clip = 1'b0;
    if (sum > ACC_MAX) begin
      acc_sat  = ACC_MAX;
      acc_clip = 1'b1;
    end else if (sum < ACC_MIN) begin
      acc_sat  = ACC_MIN;
      acc_clip = 1'b1;
    end
    acc_next  = acc_sat[ACC_W-1:0];
    flag_next = (p_first ? 1'b0 : wflag) | term_clip | acc_clip;

    res_sat  = acc_sat;
    res_clip = 1'b0;
    if (acc_sat > RES_MAX) begin
      res_sat  = RES_MAX;
      res_clip = 1'b1;
    end else if (acc_sat < RES_MIN) begin
      res_sat  = RES_MIN;
      res_clip = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      wflag     <= 1'b0;
      result    <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      wflag     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (p_valid) begin
        acc   <= acc_next;
        wflag <= flag_next;
        if (p_last) begin
          result    <= res_sat[DATA_W-1:0];
          sat       <= flag_next | res_clip;
          out_valid <= 1'b1;
        end
      end
    end
  end

  assign busy = (cnt != '0) | p_valid;

endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum with LEN=4, signed Q8.8 operands.
module tb_mac_accum;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [15:0] pixel;
  logic [15:0] weight;
  logic [15:0] result;
  logic        out_valid;
  logic        sat;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int ov_cnt = 0;
  logic [15:0] res_q[$];
  logic        sat_q[$];

  mac_accum #(
    .DATA_W(16),
    .FRAC_W(8),
    .ACC_W (24),
    .LEN   (4),
    .SIGNED(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_valid (in_valid),
    .pixel    (pixel),
    .weight   (weight),
    .result   (result),
    .out_valid(out_valid),
    .sat      (sat),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) begin
      ov_cnt++;
      res_q.push_back(result);
      sat_q.push_back(sat);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: signed Q8.8 products, floor shift, 24-bit then 16-bit clamps.
  task automatic gold(input logic [15:0] p[4], input logic [15:0] w[4],
                      output logic [15:0] r, output logic s);
    longint acc_m, t;
    s = 1'b0;
    acc_m = 0;
    for (int i = 0; i < 4; i++) begin
      t = (longint'($signed(p[i])) * longint'($signed(w[i]))) >>> 8;
      if (t > 64'sd8388607)  begin t = 64'sd8388607;  s = 1'b1; end
      if (t < -64'sd8388608) begin t = -64'sd8388608; s = 1'b1; end
      acc_m = (i == 0) ? t : acc_m + t;
      if (acc_m > 64'sd8388607)  begin acc_m = 64'sd8388607;  s = 1'b1; end
      if (acc_m < -64'sd8388608) begin acc_m = -64'sd8388608; s = 1'b1; end
    end
    if (acc_m > 64'sd32767)  begin acc_m = 64'sd32767;  s = 1'b1; end
    if (acc_m < -64'sd32768) begin acc_m = -64'sd32768; s = 1'b1; end
    r = 16'(acc_m);
  endtask

  task automatic run_window(input string tag, input logic [15:0] p[4], input logic [15:0] w[4],
                            input logic [15:0] er, input logic es);
    int lat;
    int n0;
    n0 = ov_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      pixel    = p[i];
      weight   = w[i];
    end
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, lat, 2);
    check({tag, "_res"}, result, er);
    check({tag, "_sat"}, sat, es);
    @(negedge clk);
    check({tag, "_pulse"}, out_valid, 1'b0);
    check({tag, "_count"}, ov_cnt - n0, 1);
  endtask

  logic [15:0] pa[4], wa[4];
  logic [15:0] pr[8], wr[8];
  logic [15:0] g_res[2];
  logic        g_sat[2];
  int          n0;

  initial begin
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; pixel = '0; weight = '0;
    repeat (2) @(negedge clk);
    check("rst_res",  result,    16'h0000);
    check("rst_ov",   out_valid, 1'b0);
    check("rst_sat",  sat,       1'b0);
    check("rst_busy", busy,      1'b0);
    reset = 1'b1;
    @(negedge clk);

    pa = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    wa = '{16'h0200, 16'h0200, 16'h0200, 16'h0200};
    run_window("w_pos", pa, wa, 16'h0800, 1'b0);

    pa = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
    wa = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    run_window("w_neg", pa, wa, 16'hFC00, 1'b0);

    pa = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    wa = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    run_window("w_sat", pa, wa, 16'h7FFF, 1'b1);

    pa = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    wa = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    run_window("w_after_sat", pa, wa, 16'h0400, 1'b0);

    // two windows streamed with random gaps; first pass fully back-to-back
    for (int it = 0; it < 2; it++) begin
      for (int i = 0; i < 8; i++) begin
        pr[i] = 16'($urandom);
        wr[i] = (i < 4) ? 16'($urandom) : 16'($urandom_range(0, 16'h03FF)) - 16'h0200;
      end
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++) begin
          pa[i] = pr[4*k + i];
          wa[i] = wr[4*k + i];
        end
        gold(pa, wa, g_res[k], g_sat[k]);
      end
      n0 = ov_cnt;
      res_q.delete();
      sat_q.delete();
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        in_valid = 1'b1;
        pixel    = pr[i];
        weight   = wr[i];
        if (it != 0) begin
          repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            in_valid = 1'b0;
          end
        end
      end
      repeat (4) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      check("rnd_count", ov_cnt - n0, 2);
      if (res_q.size() >= 2) begin
        check("rnd_res0", res_q[0], g_res[0]);
        check("rnd_sat0", sat_q[0], g_sat[0]);
        check("rnd_res1", res_q[1], g_res[1]);
        check("rnd_sat1", sat_q[1], g_sat[1]);
      end
    end

    // abort a partial window; junk input during clear must be ignored
    n0 = ov_cnt;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; pixel = 16'h1234; weight = 16'h0567;
    end
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; pixel = 16'h4000; weight = 16'h4000;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    check("clr_busy", busy, 1'b0);
    pa = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    wa = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    run_window("clr_next", pa, wa, 16'h0400, 1'b0);
    check("clr_abort_count", ov_cnt - n0, 1);

    // clear right after the last term kills the pending result
    n0 = ov_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; pixel = 16'h0200; weight = 16'h0100;
    end
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);
    check("clr_last_count", ov_cnt - n0, 0);
    check("clr_last_hold", result, 16'h0400);
    check("clr_last_busy", busy, 1'b0);

    // asynchronous reset in mid-window
    n0 = ov_cnt;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; pixel = 16'h0100; weight = 16'h0100;
    end
    #2 reset = 1'b0;
    #1;
    check("arst_res",  result,    16'h0000);
    check("arst_ov",   out_valid, 1'b0);
    check("arst_busy", busy,      1'b0);
    check("arst_sat",  sat,       1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_count", ov_cnt - n0, 0);
    pa = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    wa = '{16'h0300, 16'h0300, 16'h0300, 16'h0300};
    run_window("arst_next", pa, wa, 16'h0C00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
